// File: rtl/prog_loader_if.sv
// Host byte-stream port of the program loader: received-byte strobe in, transmit handshake out.
interface prog_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
   modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/prog_loader.sv
// Program loader / run controller: loads and dumps RAM over the host byte stream while the
// cpu is held in reset, then starts the cpu at a chosen address and reports when it halts.
module prog_loader #(
   parameter int addr_width = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   prog_loader_if.slave          io_host,
   output logic [addr_width-1:0] o_mem_raddr,
   output logic [addr_width-1:0] o_mem_waddr,
   output logic [7:0]            o_mem_data_in,
   output logic                  o_mem_write,
   input  logic [7:0]            i_mem_data_out,
   output logic                  o_mem_owner,
   output logic                  o_cpu_reset,
   output logic                  o_cpu_halt,
   input  logic                  i_cpu_halted,
   output logic [addr_width-1:0] o_start_address
);
   localparam logic [7:0] ACK_BYTE  = 8'h06;
   localparam logic [7:0] NAK_BYTE  = 8'h15;
   localparam logic [7:0] HALT_BYTE = 8'h48;
   localparam logic [7:0] CMD_L     = 8'h4C;
   localparam logic [7:0] CMD_D     = 8'h44;
   localparam logic [7:0] CMD_E     = 8'h45;
   localparam logic [7:0] CMD_S     = 8'h53;

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_LDATA, S_LCHK, S_DRD, S_DCAP, S_DTX, S_EXEC, S_RUN, S_STOP, S_RESP
   } state_t;
   typedef enum logic [1:0] {OP_LOAD, OP_DUMP, OP_EXEC} op_t;

   state_t                r_state, w_state;
   op_t                   r_op, w_op;
   logic [1:0]            r_cnt, w_cnt;
   logic [15:0]           r_addr, w_addr, r_len, w_len;
   logic [15:0]           w_addr_shift, w_len_shift, w_addr_inc;
   logic [7:0]            r_sum, w_sum, r_tx_data, w_tx_data;
   logic                  r_tx_valid, w_tx_valid, r_ret_run, w_ret_run;
   logic [addr_width-1:0] r_mem_raddr, w_mem_raddr, r_mem_waddr, w_mem_waddr;
   logic [addr_width-1:0] r_start_address, w_start_address;
   logic [7:0]            r_mem_data_in, w_mem_data_in;
   logic                  r_mem_write, w_mem_write, r_mem_owner, w_mem_owner;
   logic                  r_cpu_reset, w_cpu_reset, r_cpu_halt, w_cpu_halt;
   logic                  w_rx, w_tx_done, w_halt, w_resp_en, w_resp_run;
   logic [7:0]            w_rx_byte, w_resp_byte;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_op            <= OP_LOAD;
         r_cnt           <= 2'd0;
         r_addr          <= 16'd0;
         r_len           <= 16'd0;
         r_sum           <= 8'd0;
         r_tx_data       <= 8'd0;
         r_tx_valid      <= 1'b0;
         r_ret_run       <= 1'b0;
         r_mem_raddr     <= '0;
         r_mem_waddr     <= '0;
         r_mem_data_in   <= 8'd0;
         r_mem_write     <= 1'b0;
         r_mem_owner     <= 1'b1;
         r_cpu_reset     <= 1'b1;
         r_cpu_halt      <= 1'b0;
         r_start_address <= '0;
      end else begin
         r_state         <= w_state;
         r_op            <= w_op;
         r_cnt           <= w_cnt;
         r_addr          <= w_addr;
         r_len           <= w_len;
         r_sum           <= w_sum;
         r_tx_data       <= w_tx_data;
         r_tx_valid      <= w_tx_valid;
         r_ret_run       <= w_ret_run;
         r_mem_raddr     <= w_mem_raddr;
         r_mem_waddr     <= w_mem_waddr;
         r_mem_data_in   <= w_mem_data_in;
         r_mem_write     <= w_mem_write;
         r_mem_owner     <= w_mem_owner;
         r_cpu_reset     <= w_cpu_reset;
         r_cpu_halt      <= w_cpu_halt;
         r_start_address <= w_start_address;
      end
   end

   always_comb begin
      w_state         = r_state;
      w_op            = r_op;
      w_cnt           = r_cnt;
      w_addr          = r_addr;
      w_len           = r_len;
      w_sum           = r_sum;
      w_tx_data       = r_tx_data;
      w_tx_valid      = r_tx_valid;
      w_ret_run       = r_ret_run;
      w_mem_raddr     = r_mem_raddr;
      w_mem_waddr     = r_mem_waddr;
      w_mem_data_in   = r_mem_data_in;
      w_mem_write     = 1'b0;
      w_mem_owner     = r_mem_owner;
      w_cpu_reset     = r_cpu_reset;
      w_cpu_halt      = r_cpu_halt;
      w_start_address = r_start_address;
      w_halt          = 1'b0;
      w_resp_en       = 1'b0;
      w_resp_byte     = NAK_BYTE;
      w_resp_run      = 1'b0;
      w_rx            = io_host.rx_valid;
      w_rx_byte       = io_host.rx_data;
      w_tx_done       = r_tx_valid & io_host.tx_ready;
      w_addr_shift    = {r_addr[7:0], w_rx_byte};
      w_len_shift     = {r_len[7:0], w_rx_byte};
      w_addr_inc      = r_addr + 16'd1;

      case (r_state)
         S_IDLE: if (w_rx) begin
            w_cnt   = 2'd0;
            w_state = S_HDR;
            case (w_rx_byte)
               CMD_L:   w_op = OP_LOAD;
               CMD_D:   w_op = OP_DUMP;
               CMD_E:   w_op = OP_EXEC;
               default: w_resp_en = 1'b1;
            endcase
         end
         S_HDR: if (w_rx) begin
            w_cnt = r_cnt + 2'd1;
            if (!r_cnt[1]) w_addr = w_addr_shift;
            else           w_len  = w_len_shift;
            if (r_op == OP_EXEC && r_cnt == 2'd1) begin
               // ACK is presented now; EXEC releases the cpu one cycle later
               w_start_address = w_addr_shift[addr_width-1:0];
               w_tx_data       = ACK_BYTE;
               w_tx_valid      = 1'b1;
               w_state         = S_EXEC;
            end else if (r_cnt == 2'd3) begin
               w_sum = 8'd0;
               if (r_op == OP_LOAD) begin
                  w_state = (w_len_shift == 16'd0) ? S_LCHK : S_LDATA;
               end else if (w_len_shift == 16'd0) begin
                  w_resp_en   = 1'b1;
                  w_resp_byte = ACK_BYTE;
               end else begin
                  w_mem_raddr = r_addr[addr_width-1:0];
                  w_state     = S_DRD;
               end
            end
         end
         S_LDATA: if (w_rx) begin
            w_mem_write   = 1'b1;
            w_mem_waddr   = r_addr[addr_width-1:0];
            w_mem_data_in = w_rx_byte;
            w_addr        = w_addr_inc;
            w_sum         = r_sum + w_rx_byte;
            w_len         = r_len - 16'd1;
            if (r_len == 16'd1) w_state = S_LCHK;
         end
         S_LCHK: if (w_rx) begin
            w_resp_en   = 1'b1;
            w_resp_byte = (w_rx_byte == r_sum) ? ACK_BYTE : NAK_BYTE;
         end
         S_DRD: w_state = S_DCAP;
         S_DCAP: begin
            w_tx_data  = i_mem_data_out;
            w_tx_valid = 1'b1;
            w_state    = S_DTX;
         end
         S_DTX: if (w_tx_done) begin
            w_addr = w_addr_inc;
            w_len  = r_len - 16'd1;
            if (r_len == 16'd1) begin
               w_resp_en   = 1'b1;
               w_resp_byte = ACK_BYTE;
            end else begin
               w_tx_valid  = 1'b0;
               w_mem_raddr = w_addr_inc[addr_width-1:0];
               w_state     = S_DRD;
            end
         end
         S_EXEC: begin
            w_mem_owner = 1'b0;
            w_cpu_reset = 1'b0;
            if (w_tx_done) begin
               w_tx_valid = 1'b0;
               w_state    = S_RUN;
            end else begin
               w_ret_run = 1'b1;
               w_state   = S_RESP;
            end
         end
         S_RUN: begin
            if (i_cpu_halted) begin
               w_halt = 1'b1;
            end else if (w_rx) begin
               if (w_rx_byte == CMD_S) begin
                  w_cpu_halt = 1'b1;
                  w_state    = S_STOP;
               end else begin
                  w_resp_en  = 1'b1;
                  w_resp_run = 1'b1;
               end
            end
         end
         S_STOP: if (i_cpu_halted) w_halt = 1'b1;
         S_RESP: if (w_tx_done) begin
            w_tx_valid = 1'b0;
            w_state    = r_ret_run ? S_RUN : S_IDLE;
         end
         default: w_state = S_IDLE;
      endcase

      if (w_halt) begin
         w_cpu_halt  = 1'b0;
         w_cpu_reset = 1'b1;
         w_mem_owner = 1'b1;
         w_resp_en   = 1'b1;
         w_resp_byte = HALT_BYTE;
      end
      if (w_resp_en) begin
         w_tx_data  = w_resp_byte;
         w_tx_valid = 1'b1;
         w_ret_run  = w_resp_run;
         w_state    = S_RESP;
      end
   end

   assign io_host.tx_data  = r_tx_data;
   assign io_host.tx_valid = r_tx_valid;
   assign o_mem_raddr      = r_mem_raddr;
   assign o_mem_waddr      = r_mem_waddr;
   assign o_mem_data_in    = r_mem_data_in;
   assign o_mem_write      = r_mem_write;
   assign o_mem_owner      = r_mem_owner;
   assign o_cpu_reset      = r_cpu_reset;
   assign o_cpu_halt       = r_cpu_halt;
   assign o_start_address  = r_start_address;
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: host frames drive a reference RAM image; a monitor
// checks every transmitted byte and every RAM write (address, data, cycle) against queues.
module tb_prog_loader;
   localparam int AW       = 9;
   localparam int MEM_SIZE = 1 << AW;
   localparam logic [7:0] ACK = 8'h06, NAK = 8'h15, HLT = 8'h48;

   typedef struct {
      int         addr;
      logic [7:0] data;
      int         cyc;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] mem_raddr, mem_waddr, start_address;
   logic [7:0]    mem_data_in;
   logic [7:0]    mem_data_out;
   logic          mem_write, mem_owner, cpu_reset, cpu_halt;
   logic          cpu_halted;

   logic [7:0]    ram     [MEM_SIZE];
   logic [7:0]    ref_mem [MEM_SIZE];
   logic [7:0]    tx_q[$];
   wr_t           wr_q[$];

   int n_vec = 0, n_bad = 0;
   int cyc = 0;
   int last_stamp = 0;
   int halt_after = 50;
   bit force_stall = 1'b0;
   bit prev_stall = 1'b0;
   logic [7:0] prev_data = 8'd0;

   prog_loader_if host_if ();

   prog_loader #(.addr_width(AW)) dut (
      .clk             (clk),
      .reset           (reset),
      .io_host         (host_if),
      .o_mem_raddr     (mem_raddr),
      .o_mem_waddr     (mem_waddr),
      .o_mem_data_in   (mem_data_in),
      .o_mem_write     (mem_write),
      .i_mem_data_out  (mem_data_out),
      .o_mem_owner     (mem_owner),
      .o_cpu_reset     (cpu_reset),
      .o_cpu_halt      (cpu_halt),
      .i_cpu_halted    (cpu_halted),
      .o_start_address (start_address)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // synchronous RAM: one-cycle read latency
   initial begin
      for (int i = 0; i < MEM_SIZE; i++) ram[i] = 8'd0;
      mem_data_out = 8'd0;
      forever begin
         @(posedge clk);
         if (mem_write === 1'b1) ram[mem_waddr] = mem_data_in;
         mem_data_out <= ram[mem_raddr];
      end
   end

   // cpu: halts on its own after halt_after running cycles, or 3 cycles into a halt request
   initial begin
      int run_cnt, halt_cnt;
      cpu_halted = 1'b0;
      run_cnt = 0;
      halt_cnt = 0;
      forever begin
         @(negedge clk);
         if (cpu_reset !== 1'b0) begin
            run_cnt = 0; halt_cnt = 0; cpu_halted = 1'b0;
         end else begin
            run_cnt++;
            if (cpu_halt) halt_cnt++;
            if (run_cnt >= halt_after || halt_cnt >= 3) cpu_halted = 1'b1;
         end
      end
   end

   initial begin
      host_if.tx_ready = 1'b0;
      forever begin
         @(negedge clk);
         host_if.tx_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input logic [31:0] act);
      n_vec++;
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected nothing", name, act);
   endtask

   initial begin
      logic [7:0] exp_b;
      wr_t        exp_w;
      forever begin
         @(negedge clk);
         #1;
         if (reset) begin
            prev_stall = 1'b0;
            continue;
         end
         if (prev_stall) check("tx_hold", {23'd0, host_if.tx_valid, host_if.tx_data}, {23'd0, 1'b1, prev_data});
         if (host_if.tx_valid && host_if.tx_ready) begin
            if (tx_q.size() == 0) flag("tx_unexpected", host_if.tx_data);
            else begin
               exp_b = tx_q.pop_front();
               check("tx_byte", host_if.tx_data, exp_b);
            end
         end
         prev_stall = host_if.tx_valid && !host_if.tx_ready;
         prev_data  = host_if.tx_data;
         if (mem_write === 1'b1) begin
            if (wr_q.size() == 0) flag("wr_unexpected", mem_waddr);
            else begin
               exp_w = wr_q.pop_front();
               check("wr_addr", mem_waddr, exp_w.addr);
               check("wr_data", mem_data_in, exp_w.data);
               check("wr_cycle", cyc, exp_w.cyc);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      host_if.rx_data  = b;
      host_if.rx_valid = 1'b1;
      last_stamp = cyc;
      @(negedge clk);
      host_if.rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drain();
      int budget = 3000;
      while ((tx_q.size() != 0 || wr_q.size() != 0) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         flag("drain_timeout", tx_q.size() + wr_q.size());
         tx_q.delete();
         wr_q.delete();
      end
      idle(2);
   endtask

   task automatic do_load(input logic [15:0] addr, input logic [7:0] data[$], input logic [7:0] chk);
      logic [7:0] sum = 8'd0;
      wr_t w;
      foreach (data[i]) sum += data[i];
      send_byte(8'h4C); idle($urandom_range(0, 2));
      send_byte(addr[15:8]); idle($urandom_range(0, 2));
      send_byte(addr[7:0]); idle($urandom_range(0, 2));
      send_byte(8'(data.size() >> 8)); idle($urandom_range(0, 2));
      send_byte(8'(data.size())); idle($urandom_range(0, 2));
      foreach (data[i]) begin
         send_byte(data[i]);
         w.addr = (int'(addr) + i) % MEM_SIZE;
         w.data = data[i];
         w.cyc  = last_stamp + 1;
         wr_q.push_back(w);
         ref_mem[w.addr] = data[i];
         idle($urandom_range(0, 2));
      end
      tx_q.push_back((sum == chk) ? ACK : NAK);
      send_byte(chk);
      check("load_resp_latency", host_if.tx_valid, 1'b1);
      wait_drain();
   endtask

   task automatic do_dump(input logic [15:0] addr, input int len, input bit stall);
      for (int i = 0; i < len; i++) tx_q.push_back(ref_mem[(int'(addr) + i) % MEM_SIZE]);
      tx_q.push_back(ACK);
      if (stall) force_stall = 1'b1;
      send_byte(8'h44); idle($urandom_range(0, 2));
      send_byte(addr[15:8]); idle($urandom_range(0, 2));
      send_byte(addr[7:0]); idle($urandom_range(0, 2));
      send_byte(8'(len >> 8)); idle($urandom_range(0, 2));
      send_byte(8'(len));
      if (len == 0) check("dump_empty_latency", host_if.tx_valid, 1'b1);
      if (stall) begin
         int b = 20;
         while (!host_if.tx_valid && b > 0) begin @(negedge clk); b--; end
         check("dump_first_valid", host_if.tx_valid, 1'b1);
         idle(5);
         force_stall = 1'b0;
      end
      wait_drain();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_cpu_reset"}, cpu_reset, 1'b1);
      check({tag, "_mem_owner"}, mem_owner, 1'b1);
      check({tag, "_cpu_halt"}, cpu_halt, 1'b0);
      check({tag, "_mem_write"}, mem_write, 1'b0);
      check({tag, "_tx_valid"}, host_if.tx_valid, 1'b0);
      check({tag, "_tx_data"}, host_if.tx_data, 8'h00);
      check({tag, "_start_addr"}, start_address, 0);
      check({tag, "_raddr"}, mem_raddr, 0);
      check({tag, "_waddr"}, mem_waddr, 0);
      check({tag, "_data_in"}, mem_data_in, 8'h00);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] sum, chk, bad;
      host_if.rx_valid = 1'b0;
      host_if.rx_data  = 8'h00;
      for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 8'd0;
      idle(3);
      reset = 1'b0;
      check_reset_values("rst");

      q = '{8'hAA, 8'hBB, 8'hCC};
      do_load(16'h0010, q, 8'h31);
      do_load(16'h0010, q, 8'h00);
      q = '{8'($urandom), 8'($urandom)};
      do_load(16'h01FF, q, q[0] + q[1]);
      do_dump(16'h01FF, 2, 1'b1);
      do_dump(16'h0010, 3, 1'b0);

      // execute, cpu halts by itself
      halt_after = 50;
      tx_q.push_back(ACK);
      tx_q.push_back(HLT);
      send_byte(8'h45); idle($urandom_range(0, 2));
      send_byte(8'h00); idle($urandom_range(0, 2));
      send_byte(8'h02);
      check("exec_start_address", start_address, 2);
      check("exec_cpu_reset_held", cpu_reset, 1'b1);
      check("exec_ack_latency", host_if.tx_valid, 1'b1);
      @(negedge clk);
      check("exec_cpu_reset_low", cpu_reset, 1'b0);
      check("exec_mem_owner", mem_owner, 1'b0);
      wait_drain();
      check("halt_cpu_reset", cpu_reset, 1'b1);
      check("halt_mem_owner", mem_owner, 1'b1);

      // execute, bad byte in RUN, then forced stop
      halt_after = 1000000;
      tx_q.push_back(ACK);
      send_byte(8'h45); send_byte(8'h01); send_byte(8'h40);
      wait_drain();
      check("run_start_address", start_address, 9'h140);
      tx_q.push_back(NAK);
      send_byte(8'h58);
      wait_drain();
      check("run_kept_cpu_reset", cpu_reset, 1'b0);
      check("run_kept_mem_owner", mem_owner, 1'b0);
      tx_q.push_back(HLT);
      send_byte(8'h53);
      begin
         int b = 20;
         while (!cpu_halt && b > 0) begin @(negedge clk); b--; end
      end
      check("stop_cpu_halt", cpu_halt, 1'b1);
      wait_drain();
      check("stop_cpu_halt_clear", cpu_halt, 1'b0);
      check("stop_cpu_reset", cpu_reset, 1'b1);
      check("stop_mem_owner", mem_owner, 1'b1);

      // randomized frames against the RAM image
      for (int f = 0; f < 24; f++) begin
         int kind = $urandom_range(0, 9);
         if (kind <= 4) begin
            q.delete();
            sum = 8'd0;
            for (int i = 0; i < $urandom_range(0, 8); i++) begin
               q.push_back(8'($urandom));
               sum += q[i];
            end
            chk = ($urandom_range(0, 4) == 0) ? sum + 8'($urandom_range(1, 255)) : sum;
            do_load(16'($urandom), q, chk);
         end else if (kind <= 8) begin
            do_dump(16'($urandom), $urandom_range(0, 8), 1'b0);
         end else begin
            do bad = 8'($urandom); while (bad == 8'h4C || bad == 8'h44 || bad == 8'h45);
            tx_q.push_back(NAK);
            send_byte(bad);
            check("badcmd_latency", host_if.tx_valid, 1'b1);
            wait_drain();
         end
      end

      // reset in the middle of a load frame; a byte arriving with reset is ignored
      send_byte(8'h4C); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h04);
      reset = 1'b1;
      host_if.rx_data  = 8'h5A;
      host_if.rx_valid = 1'b1;
      @(negedge clk);
      host_if.rx_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check_reset_values("midrst");
      idle(12);
      tx_q.push_back(NAK);
      send_byte(8'h5A);
      wait_drain();
      do_dump(16'h0010, 3, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
